// File: rtl/ex_pipe_reg_chain.sv
// ex_pipe_reg_chain: parametrised execute-stage register bank.
// DEPTH stages, each holding a valid bit, a CTRL_W control vector and
// LANES data words of DATA_W bits. Stage DEPTH-1 drives the outputs.
//
// Handshake: an entry moves across a boundary on a rising edge when the
// producer's valid and the consumer's ready are both high in that cycle.
// Ready is combinational from the output back to the input. Any stage
// that does not hold a valid entry always takes the entry behind it. This
// lets bubbles collapse under backpressure.
//
// Flush kills every in-flight entry: valid and control bits are cleared.
// Data words are left as they are. Control of an invalid stage is always
// zero, so a bubble can never assert a write enable downstream.
//
// Optional build macro: EX_PIPE_LANE_GATE_EN adds In_LaneEn. That port
// is a per-entry lane mask. A masked-off lane keeps its old value on
// every load, which saves power when SAD lanes are idle.
module ex_pipe_reg_chain #(
  parameter int DATA_W = 32,
  parameter int LANES  = 8,
  parameter int CTRL_W = 12,
  parameter int DEPTH  = 1
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         Flush,
  input  logic                         In_Valid,
  output logic                         In_Ready,
  input  logic [CTRL_W-1:0]            In_Ctrl,
  input  logic [LANES*DATA_W-1:0]      In_Data,
`ifdef EX_PIPE_LANE_GATE_EN
  input  logic [LANES-1:0]             In_LaneEn,
`endif
  output logic                         Out_Valid,
  input  logic                         Out_Ready,
  output logic [CTRL_W-1:0]            Out_Ctrl,
  output logic [LANES*DATA_W-1:0]      Out_Data,
  output logic [$clog2(DEPTH+1)-1:0]   Occupancy
);

  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int LAST  = DEPTH - 1;

  logic [DEPTH-1:0]          v;
  logic [CTRL_W-1:0]         c [DEPTH];
  logic [LANES*DATA_W-1:0]   d [DEPTH];
  logic [DEPTH-1:0]          adv;
  logic                      accept;
  logic [OCC_W-1:0]          occ;
`ifdef EX_PIPE_LANE_GATE_EN
  logic [LANES-1:0]          m [DEPTH];
`endif

  // Ready chain: a stage can take a new entry if it is empty or its contents move on
  always_comb begin
    adv = '0;
    adv[LAST] = !v[LAST] | Out_Ready;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      adv[i] = !v[i] | adv[i + 1];
    end
  end

  assign In_Ready = adv[0] & !Flush;
  assign accept   = In_Valid & In_Ready;

  // Stage registers: reset clears all, flush kills valid/ctrl, otherwise shift where allowed
  always_ff @(posedge Clk) begin
    if (Reset) begin
      v <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        c[i] <= '0;
        d[i] <= '0;
`ifdef EX_PIPE_LANE_GATE_EN
        m[i] <= '0;
`endif
      end
    end else if (Flush) begin
      v <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        c[i] <= '0;
      end
    end else begin
      if (adv[0]) begin
        v[0] <= accept;
        c[0] <= accept ? In_Ctrl : '0;
`ifdef EX_PIPE_LANE_GATE_EN
        m[0] <= In_LaneEn;
        for (int k = 0; k < LANES; k++) begin
          if (In_LaneEn[k]) begin
            d[0][k*DATA_W +: DATA_W] <= In_Data[k*DATA_W +: DATA_W];
          end
        end
`else
        d[0] <= In_Data;
`endif
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (adv[i]) begin
          v[i] <= v[i - 1];
          c[i] <= c[i - 1];
`ifdef EX_PIPE_LANE_GATE_EN
          m[i] <= m[i - 1];
          for (int k = 0; k < LANES; k++) begin
            if (m[i - 1][k]) begin
              d[i][k*DATA_W +: DATA_W] <= d[i - 1][k*DATA_W +: DATA_W];
            end
          end
`else
          d[i] <= d[i - 1];
`endif
        end
      end
    end
  end

  // Occupancy: number of valid stages
  always_comb begin
    occ = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ = occ + OCC_W'(v[i]);
    end
  end

  assign Occupancy = occ;
  assign Out_Valid = v[LAST];
  assign Out_Ctrl  = v[LAST] ? c[LAST] : '0;
  assign Out_Data  = d[LAST];

endmodule
